interpolate_2: RTL and testbench

- Upsamples a sample stream by 2 using linear interpolation; the counterpart of the 2-tap averaging/decimating stage.
- For each accepted input, emits the midpoint between the previous and current input, then the current input.
- Sits between the locking-loop DSP output and the DAC drive path, filling the DAC at twice the loop sample rate.
- Sample width is the package constant word_width, two's complement.

---
 rtl/interpolate_2_if.sv | 28 ++
 rtl/interpolate_2.sv | 112 +++++++++++
 tb/tb_interpolate_2.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/interpolate_2_if.sv
// Shared sample-width constant and the sample-stream bundle of the 2x linear interpolator.
// The DUT uses the slave modport; the producer/consumer side uses master.
package interpolate_2_pkg;
   localparam int word_width = 14;
endpackage

interface interpolate_2_if;
   import interpolate_2_pkg::*;

   logic                         enable;
   logic signed [word_width-1:0] sample_in;
   logic                         sample_in_valid;
   logic                         sample_in_ready;
   logic signed [word_width-1:0] sample_out;
   logic                         sample_out_valid;
   logic                         overrun;
   logic                         overrun_clr;

   modport master (
      output enable, sample_in, sample_in_valid, overrun_clr,
      input  sample_in_ready, sample_out, sample_out_valid, overrun
   );

   modport slave (
      input  enable, sample_in, sample_in_valid, overrun_clr,
      output sample_in_ready, sample_out, sample_out_valid, overrun
   );
endinterface

// File: rtl/interpolate_2.sv
// 2x linear-interpolating upsampler: each accepted input emits the midpoint with the previous
// input, optionally GAP idle cycles, then the input itself; enable=0 passes samples straight through.
module interpolate_2
   import interpolate_2_pkg::*;
#(
   parameter int GAP = 0
) (
   input  logic               clk,
   input  logic               rst,
   interpolate_2_if.slave     bus
);

   localparam int W        = word_width;
   localparam int CNT_W    = 4;
   localparam int CNT_INIT = (GAP > 0) ? GAP - 1 : 0;

   typedef enum logic [1:0] {IDLE, MID, WAIT, CUR} state_t;

   state_t                r_state;
   logic signed [W-1:0]   r_prev;
   logic signed [W-1:0]   r_cur;
   logic signed [W-1:0]   r_out;
   logic                  r_out_vld;
   logic                  r_overrun;
   logic [CNT_W-1:0]      r_cnt;

   logic                  w_ready;
   logic                  w_accept;
   logic signed [W-1:0]   w_mid;

   // Floor of the mean: one guard bit on the sum means the result can never overflow.
   function automatic logic signed [W-1:0] midpoint(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
      logic signed [W:0] sum;
      sum = {a[W-1], a} + {b[W-1], b};
      return sum[W:1];
   endfunction

   assign w_ready  = (r_state == IDLE) || (r_state == CUR);
   assign w_accept = bus.sample_in_valid && w_ready;
   assign w_mid    = midpoint(r_prev, bus.sample_in);

   assign bus.sample_in_ready  = w_ready;
   assign bus.sample_out       = r_out;
   assign bus.sample_out_valid = r_out_vld;
   assign bus.overrun          = r_overrun;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_prev    <= '0;
         r_cur     <= '0;
         r_out     <= '0;
         r_out_vld <= 1'b0;
         r_overrun <= 1'b0;
         r_cnt     <= '0;
      end else begin
         // Set has priority over clear so a simultaneous drop is never lost.
         if (bus.sample_in_valid && !w_ready)
            r_overrun <= 1'b1;
         else if (bus.overrun_clr)
            r_overrun <= 1'b0;

         r_out_vld <= 1'b0;

         case (r_state)
            IDLE, CUR: begin
               if (w_accept) begin
                  r_out_vld <= 1'b1;
                  if (bus.enable) begin
                     r_out   <= w_mid;
                     r_cur   <= bus.sample_in;
                     r_state <= MID;
                  end else begin
                     r_out   <= bus.sample_in;
                     r_prev  <= bus.sample_in;
                     r_state <= CUR;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end

            MID: begin
               if (GAP == 0) begin
                  r_out     <= r_cur;
                  r_out_vld <= 1'b1;
                  r_prev    <= r_cur;
                  r_state   <= CUR;
               end else begin
                  r_cnt   <= CNT_W'(CNT_INIT);
                  r_state <= WAIT;
               end
            end

            WAIT: begin
               if (r_cnt == '0) begin
                  r_out     <= r_cur;
                  r_out_vld <= 1'b1;
                  r_prev    <= r_cur;
                  r_state   <= CUR;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_interpolate_2.sv
// Directed bench for interpolate_2: one GAP=0 instance and one GAP=3 instance on a shared clock.
module tb_interpolate_2;
   import interpolate_2_pkg::*;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   interpolate_2_if if0 ();
   interpolate_2_if if3 ();

   interpolate_2 #(.GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   interpolate_2 #(.GAP(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // One interpolated pair on the GAP=0 instance; returns with the block idle.
   task automatic send0(input string tag, input int x, input int exp_mid);
      if0.sample_in       = x[word_width-1:0];
      if0.sample_in_valid = 1'b1;
      @(negedge clk);
      if0.sample_in_valid = 1'b0;
      chk({tag, "_mid"},     int'(if0.sample_out), exp_mid);
      chk({tag, "_mid_vld"}, int'(if0.sample_out_valid), 1);
      @(negedge clk);
      chk({tag, "_cur"},     int'(if0.sample_out), x);
      chk({tag, "_cur_vld"}, int'(if0.sample_out_valid), 1);
      @(negedge clk);
      chk({tag, "_idle"},    int'(if0.sample_out_valid), 0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b0;
      if0.enable = 1'b1; if0.sample_in = '0; if0.sample_in_valid = 1'b0; if0.overrun_clr = 1'b0;
      if3.enable = 1'b1; if3.sample_in = '0; if3.sample_in_valid = 1'b0; if3.overrun_clr = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Reset state
      chk("rst_out",     int'(if0.sample_out), 0);
      chk("rst_vld",     int'(if0.sample_out_valid), 0);
      chk("rst_ovr",     int'(if0.overrun), 0);
      chk("rst_ready",   int'(if0.sample_in_ready), 1);
      chk("rst_vld3",    int'(if3.sample_out_valid), 0);
      rst = 1'b1;
      @(negedge clk);

      // Single input, GAP=0
      if0.sample_in = 14'sd100; if0.sample_in_valid = 1'b1;
      @(negedge clk);
      if0.sample_in_valid = 1'b0;
      chk("s_mid",       int'(if0.sample_out), 50);
      chk("s_mid_vld",   int'(if0.sample_out_valid), 1);
      chk("s_mid_rdy",   int'(if0.sample_in_ready), 0);
      @(negedge clk);
      chk("s_cur",       int'(if0.sample_out), 100);
      chk("s_cur_vld",   int'(if0.sample_out_valid), 1);
      chk("s_cur_rdy",   int'(if0.sample_in_ready), 1);
      @(negedge clk);
      chk("s_end_vld",   int'(if0.sample_out_valid), 0);
      chk("s_hold",      int'(if0.sample_out), 100);

      // Back-to-back, input accepted in CUR
      do_reset();
      if0.sample_in = 14'sd100; if0.sample_in_valid = 1'b1;
      @(negedge clk);
      if0.sample_in_valid = 1'b0;
      chk("bb_o1",       int'(if0.sample_out), 50);
      chk("bb_v1",       int'(if0.sample_out_valid), 1);
      @(negedge clk);
      chk("bb_o2",       int'(if0.sample_out), 100);
      chk("bb_v2",       int'(if0.sample_out_valid), 1);
      if0.sample_in = 14'sd200; if0.sample_in_valid = 1'b1;
      @(negedge clk);
      if0.sample_in_valid = 1'b0;
      chk("bb_o3",       int'(if0.sample_out), 150);
      chk("bb_v3",       int'(if0.sample_out_valid), 1);
      @(negedge clk);
      chk("bb_o4",       int'(if0.sample_out), 200);
      chk("bb_v4",       int'(if0.sample_out_valid), 1);
      @(negedge clk);
      chk("bb_v5",       int'(if0.sample_out_valid), 0);
      chk("bb_ovr",      int'(if0.overrun), 0);

      // Sign, rounding and full-scale cases
      do_reset();
      send0("r100",   100,   50);
      send0("rm101",  -101,  -1);
      send0("r8191a", 8191,  4045);
      send0("r8191b", 8191,  8191);
      send0("rm8192a", -8192, -1);
      send0("rm8192b", -8192, -8192);
      send0("rm3",    -3,    -4098);
      send0("r0",     0,     -2);

      // GAP=3 with a dropped input while waiting
      do_reset();
      if3.sample_in = 14'sd40; if3.sample_in_valid = 1'b1;
      @(negedge clk);
      if3.sample_in_valid = 1'b0;
      chk("g_mid",       int'(if3.sample_out), 20);
      chk("g_mid_vld",   int'(if3.sample_out_valid), 1);
      @(negedge clk);
      chk("g_w1_vld",    int'(if3.sample_out_valid), 0);
      @(negedge clk);
      chk("g_w2_vld",    int'(if3.sample_out_valid), 0);
      chk("g_w2_rdy",    int'(if3.sample_in_ready), 0);
      if3.sample_in = 14'sd77; if3.sample_in_valid = 1'b1;
      @(negedge clk);
      if3.sample_in_valid = 1'b0;
      chk("g_w3_vld",    int'(if3.sample_out_valid), 0);
      chk("g_ovr_set",   int'(if3.overrun), 1);
      @(negedge clk);
      chk("g_cur",       int'(if3.sample_out), 40);
      chk("g_cur_vld",   int'(if3.sample_out_valid), 1);
      chk("g_ovr_hold",  int'(if3.overrun), 1);
      if3.overrun_clr = 1'b1;
      @(negedge clk);
      if3.overrun_clr = 1'b0;
      chk("g_ovr_clr",   int'(if3.overrun), 0);
      chk("g_end_vld",   int'(if3.sample_out_valid), 0);

      // Bypass then interpolate continuing from the bypassed sample
      do_reset();
      if0.enable = 1'b0;
      if0.sample_in = 14'sd10; if0.sample_in_valid = 1'b1;
      @(negedge clk);
      if0.sample_in_valid = 1'b0;
      chk("by_o1",       int'(if0.sample_out), 10);
      chk("by_v1",       int'(if0.sample_out_valid), 1);
      @(negedge clk);
      chk("by_gap_vld",  int'(if0.sample_out_valid), 0);
      if0.sample_in = 14'sd30; if0.sample_in_valid = 1'b1;
      @(negedge clk);
      if0.sample_in_valid = 1'b0;
      chk("by_o2",       int'(if0.sample_out), 30);
      chk("by_v2",       int'(if0.sample_out_valid), 1);
      @(negedge clk);
      chk("by_end_vld",  int'(if0.sample_out_valid), 0);
      if0.enable = 1'b1;
      send0("by_i50", 50, 40);

      // Reset in the middle of a pair
      do_reset();
      if0.sample_in = 14'sd100; if0.sample_in_valid = 1'b1;
      @(negedge clk);
      if0.sample_in_valid = 1'b0;
      chk("ra_mid",      int'(if0.sample_out), 50);
      rst = 1'b0;
      #1;
      chk("ra_out0",     int'(if0.sample_out), 0);
      chk("ra_vld0",     int'(if0.sample_out_valid), 0);
      @(negedge clk);
      rst = 1'b1;
      chk("ra_vld1",     int'(if0.sample_out_valid), 0);
      @(negedge clk);
      chk("ra_vld2",     int'(if0.sample_out_valid), 0);
      chk("ra_out2",     int'(if0.sample_out), 0);
      send0("ra_60", 60, 30);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
